// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: tick-driven UART transmit sequencer (start, LSB-first data, stop).
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
`default_nettype none
`timescale 1ns/1ps

module uart_tx_ctrl #(
   parameter int DATA_BITS    = 8,
   parameter int OVERSAMPLING = 16,
   parameter int STOP_TICKS   = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_tick,
   input  logic                 i_tx_start,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_tx_done
);

   localparam int TICK_MAX = (OVERSAMPLING > STOP_TICKS) ? OVERSAMPLING : STOP_TICKS;
   localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] C_BIT_LAST  = TW'(OVERSAMPLING - 1);
   localparam logic [TW-1:0] C_STOP_LAST = TW'(STOP_TICKS - 1);
   localparam logic [BW-1:0] C_DATA_LAST = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;
`endif

   state_t                 state_q, state_d;
   logic [TW-1:0]          tick_q, tick_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   tx_q, tx_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic                   par_q, par_d;
`endif

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            // A tick coinciding with the accepted start is deliberately not counted.
            if (i_tx_start) begin
               shift_d = i_data;
               tick_d  = '0;
               state_d = S_START;
`ifdef UART_TX_PARITY_EN
               par_d   = (^i_data) ^ (PARITY_ODD != 0);
`endif
            end
         end
         S_START: begin
            if (i_tick) begin
               if (tick_q == C_BIT_LAST) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = S_DATA;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (i_tick) begin
               if (tick_q == C_BIT_LAST) begin
                  tick_d  = '0;
                  shift_d = shift_q >> 1;
                  if (bit_q == C_DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (i_tick) begin
               if (tick_q == C_BIT_LAST) begin
                  tick_d  = '0;
                  state_d = S_STOP;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
`endif
         S_STOP: begin
            if (i_tick) begin
               if (tick_q == C_STOP_LAST) begin
                  tick_d  = '0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign o_tx      = tx_q;
   assign o_busy    = busy_q;
   assign o_tx_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: vector table, hand sequences and random traffic against a frame-position model.
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_ctrl;

   localparam int DB   = 8;
   localparam int OS   = 16;
   localparam int ST   = 16;
   localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NBITS = 2 + DB + PB;
   localparam int FRAME = (1 + DB + PB) * OS + ST;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick  = 1'b0;
   logic          start = 1'b0;
   logic [DB-1:0] data  = '0;
   logic          tx, busy, done;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   uart_tx_ctrl #(
      .DATA_BITS(DB), .OVERSAMPLING(OS), .STOP_TICKS(ST), .PARITY_ODD(PODD)
   ) dut (
      .i_clk(clk), .i_reset(rst_n), .i_tick(tick), .i_tx_start(start),
      .i_data(data), .o_tx(tx), .o_busy(busy), .o_tx_done(done)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (3) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a frame is a list of line levels, each held OS ticks, then ST ticks of stop.
   logic          m_active = 1'b0;
   logic          m_done   = 1'b0;
   int            m_k      = 0;
   logic [DB-1:0] m_data   = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_k      <= 0;
      end else if (m_active) begin
         m_done <= 1'b0;
         if (tick) begin
            m_k <= m_k + 1;
            if (m_k + 1 == FRAME) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
            end
         end
      end else begin
         m_done <= 1'b0;
         if (start) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_data   <= data;
         end
      end
   end

   function automatic logic exp_line(input logic [DB-1:0] d, input int k);
      int idx;
      if (k >= (1 + DB + PB) * OS) return 1'b1;
      idx = k / OS;
      if (idx == 0)  return 1'b0;
      if (idx <= DB) return d[idx-1];
      return (^d) ^ (PODD != 0);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_tx",   tx,   m_active ? exp_line(m_data, m_k) : 1'b1);
         chk("model_busy", busy, m_active);
         chk("model_done", done, m_done);
      end
   end

   typedef struct {
      logic [DB-1:0] d;
      logic [9:0]    line;
      logic          par_even;
   } vec_t;

   vec_t vt[6];

   function automatic logic [10:0] full_line(input logic [9:0] l, input logic pe);
      if (PB != 0) return {1'b1, pe ^ (PODD != 0), l[8:0]};
      return {1'b0, l};
   endfunction

   task automatic start_frame(input logic [DB-1:0] d, input bit hold);
      @(negedge clk);
      data  = d;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   // Entered at the negedge after the accepting edge; returns at the negedge showing o_tx_done.
   task automatic check_frame(input logic [10:0] line, input string tag, input int inj_k);
      int k = 0, last_k = -1, cyc = 0;
      bit got = 1'b0, busy_ok = 1'b1, inj_on = 1'b0;
      while (!got && cyc < FRAME * 4 + 40) begin
         @(posedge clk);
         if (tick) k++;
         cyc++;
         @(negedge clk);
         if (done) got = 1'b1;
         else if (busy !== 1'b1) busy_ok = 1'b0;
         if (k != last_k && k % OS == OS / 2 && k / OS < NBITS)
            chk({tag, "_bit"}, tx, line[k/OS]);
         if (inj_on) begin
            start  = 1'b0;
            inj_on = 1'b0;
         end
         if (k == inj_k && k != last_k) begin
            start  = 1'b1;
            data   = 8'h3C;
            inj_on = 1'b1;
         end
         last_k = k;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, got, 1);
      chk({tag, "_len"}, k, FRAME);
      chk({tag, "_busy"}, busy_ok, 1);
      chk({tag, "_busy_at_done"}, busy, 0);
   endtask

   initial begin
      int idle_bad, cnt, k, cyc;
      bit got;

      vt[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
      vt[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
      vt[2] = '{8'h81, 10'b1_10000001_0, 1'b0};
      vt[3] = '{8'h3C, 10'b1_00111100_0, 1'b0};
      vt[4] = '{8'hFE, 10'b1_11111110_0, 1'b1};
      vt[5] = '{8'h00, 10'b1_00000000_0, 1'b0};

      start = 1'b1;
      data  = 8'hA5;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      start = 1'b0;
      rst_n = 1'b1;
      chk_en = 1'b1;

      idle_bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
      end
      chk("idle_hold", idle_bad, 0);

      for (int i = 0; i < 6; i++) begin
         start_frame(vt[i].d, 1'b0);
         check_frame(full_line(vt[i].line, vt[i].par_even), "vec", -1);
         @(negedge clk);
         chk("vec_done_pulse", done, 0);
      end

      // Start of 0x3C during data bit 2 of 0xA5 must be ignored.
      start_frame(8'hA5, 1'b0);
      check_frame(full_line(10'b1_10100101_0, 1'b0), "midstart", 3 * OS + 4);
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("midstart_no_2nd_done", cnt, 0);
      chk("midstart_idle", busy, 0);

      // Start held: two frames back to back with one idle clock between them.
      start_frame(8'h00, 1'b1);
      data = 8'hFF;
      start = 1'b1;
      begin
         int kk = 0, c2 = 0;
         bit g2 = 1'b0;
         while (!g2 && c2 < FRAME * 4 + 40) begin
            @(posedge clk);
            if (tick) kk++;
            c2++;
            @(negedge clk);
            if (done) g2 = 1'b1;
            else if (kk % OS == OS / 2 && kk / OS < NBITS && tick == 1'b0 && (c2 % 4) != 0)
               ;
         end
         chk("b2b_first_done", g2, 1);
         chk("b2b_first_len", kk, FRAME);
      end
      chk("b2b_idle_tx", tx, 1);
      @(negedge clk);
      chk("b2b_start_bit", tx, 0);
      chk("b2b_busy", busy, 1);
      start = 1'b0;
      check_frame(full_line(10'b1_11111111_0, 1'b0), "b2b_ff", -1);

      // Asynchronous reset in the middle of data bit 3 of 0x55.
      start_frame(8'h55, 1'b0);
      k = 0; cyc = 0;
      while (k < 4 * OS + OS / 2 && cyc < 1000) begin
         @(posedge clk);
         if (tick) k++;
         cyc++;
      end
      chk("areset_reach_bit3", k, 4 * OS + OS / 2);
      #2;
      chk("areset_pre_tx", tx, 0);
      rst_n = 1'b0;
      #1;
      chk("areset_tx", tx, 1);
      chk("areset_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      start_frame(8'h81, 1'b0);
      check_frame(full_line(10'b1_10000001_0, 1'b0), "after_rst", -1);

      // Random traffic with stray starts and data changes; judged by the model.
      for (int r = 0; r < 12; r++) begin
         repeat ($urandom_range(0, 15)) begin
            @(negedge clk);
            data = DB'($urandom);
         end
         @(negedge clk);
         start = 1'b1;
         data  = DB'($urandom);
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            data = DB'($urandom);
         end
         start = 1'b0;
         got = 1'b0; cyc = 0;
         while (!got && cyc < FRAME * 8 + 50) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
            else begin
               data  = DB'($urandom);
               start = ($urandom_range(0, 63) == 0);
            end
         end
         start = 1'b0;
         chk("rand_done", got, 1);
      end

      repeat (FRAME * 4 + 20) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      bad++;
      $display("FAIL watchdog: got timeout expected finish at %0t", $time);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
